// File: rtl/gf180mcu_icg_bank_hyst.sv
// ----------------------------------------------------------------------------
// gf180mcu_icg_bank_hyst
//   Bank of NCH glitch-free integrated clock gates with hysteresis. Each
//   channel is a latch-based positive-edge ICG with a scan/test override (TE).
//   A per-channel OFF/ON/HOLD state machine keeps the gate open for HOLD_CYC
//   extra CLK cycles after the functional enable drops. A saturating counter
//   reports how many cycles every channel has been gated off.
//
// Ports
//   CLK     in   1      free-running source clock, rising-edge state updates
//   RN      in   1      synchronous reset, active low
//   TE      in   1      test enable, forces every gate open
//   E       in   NCH    functional enable per channel (launched from rising CLK)
//   CNT_CLR in   1      synchronous clear of GCNT (RN has priority)
//   Q       out  NCH    gated clocks, Q[i] = CLK & lat[i]
//   ACTIVE  out  NCH    registered: channel FSM is not OFF
//   ALL_OFF out  1      registered: all channels OFF and TE low last cycle
//   GCNT    out  CNT_W  saturating count of cycles with ALL_OFF high
// ----------------------------------------------------------------------------
module gf180mcu_icg_bank_hyst #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned HOLD_CYC = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             TE,
  input  logic [NCH-1:0]   E,
  input  logic             CNT_CLR,
  output logic [NCH-1:0]   Q,
  output logic [NCH-1:0]   ACTIVE,
  output logic             ALL_OFF,
  output logic [CNT_W-1:0] GCNT
);

  localparam int unsigned      CW       = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'((HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] GCNT_MAX = '1;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_ON   = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [NCH-1:0] off_d;
  logic [NCH-1:0] en;
  logic [NCH-1:0] lat;
  logic           all_off_d;

  // Next-state logic per channel plus gate enables.
  always_comb begin
    off_d     = '0;
    en        = '0;
    all_off_d = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_OFF: begin
          if (E[i]) state_d[i] = S_ON;
        end
        S_ON: begin
          if (!E[i]) begin
            if (HOLD_CYC == 0) begin
              state_d[i] = S_OFF;
            end else begin
              state_d[i] = S_HOLD;
              cnt_d[i]   = CNT_LOAD;
            end
          end
        end
        S_HOLD: begin
          if (E[i])                state_d[i] = S_ON;
          else if (cnt_q[i] == '0) state_d[i] = S_OFF;
          else                     cnt_d[i]   = cnt_q[i] - CW'(1);
        end
        default: state_d[i] = S_OFF;
      endcase
      off_d[i] = (state_d[i] == S_OFF);
      // The gate follows the next state rather than the current one: the
      // enable for edge k+1 is latched in the low phase before it, so looking
      // one state ahead makes the hold window cover exactly edges
      // k+1..k+HOLD_CYC after E falls, with no gap between E and the hold.
      // next != OFF already covers E=1, since E=1 always leads to ON.
      en[i] = TE | (RN & ~off_d[i]);
    end
    all_off_d = RN & ~TE & (&off_d);
  end

  // Enable latch: transparent while CLK is low, holds while CLK is high, so
  // an enable change during the high phase cannot shorten or create a pulse.
  always_latch begin
    if (!CLK) lat <= en;
  end

  always_comb begin
    Q = {NCH{CLK}} & lat;
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
      ACTIVE  <= '0;
      ALL_OFF <= 1'b0;
      GCNT    <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ACTIVE  <= ~off_d;
      ALL_OFF <= all_off_d;
      if (CNT_CLR)                          GCNT <= '0;
      else if (ALL_OFF && GCNT != GCNT_MAX) GCNT <= GCNT + CNT_W'(1);
    end
  end

endmodule
